// File: rtl/msk_xor_rd_if.sv
// rtl/msk_xor_rd_if.sv - input/output word stream bundle for the mask XOR reader
interface msk_xor_rd_if #(
    parameter int DW = 32
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/msk_xor_rd.sv
// rtl/msk_xor_rd.sv - snapshots a wide mask and XORs it MSB word first onto a word stream
module msk_xor_rd #(
    parameter int DW = 32,
    parameter int MW = 384
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          msk_ld,
    input  logic [MW-1:0] msk,
    input  logic          abort,
    msk_xor_rd_if.slave   bus,
    output logic          busy,
    output logic          done
);
    localparam int NW = MW / DW;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state;
    logic [MW-1:0] snapshot;
    logic [IW-1:0] idx;
    logic [DW-1:0] out_data;
    logic [DW-1:0] word;
    logic          out_valid;
    logic          out_last;
    logic          in_ready;
    logic          accept;
    logic          hand_off;

    always_comb begin
        word = '0;
        for (int k = 0; k < NW; k++) begin
            if (idx == IW'(k)) word = snapshot[MW-1-k*DW -: DW];
        end
    end

    // Ready looks through the output register so a draining word frees the slot same-cycle.
    assign in_ready = (state == RUN) && (!out_valid || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign hand_off = out_valid && bus.out_ready;
    assign busy     = (state != IDLE);

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data;
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            snapshot  <= '0;
            idx       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                snapshot  <= '0;
                idx       <= '0;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (msk_ld) begin
                            snapshot <= msk;
                            idx      <= '0;
                            state    <= RUN;
                        end
                    end
                    RUN: begin
                        if (accept) begin
                            out_data  <= bus.in_data ^ word;
                            out_valid <= 1'b1;
                            out_last  <= (idx == LAST_IDX);
                            // idx parks on the final word instead of stepping past NW-1
                            if (idx == LAST_IDX) state <= DRAIN;
                            else                 idx   <= idx + IW'(1);
                        end else if (hand_off) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end
                    end
                    DRAIN: begin
                        if (hand_off) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            if (out_last) begin
                                done  <= 1'b1;
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_msk_xor_rd.sv
// tb/tb_msk_xor_rd.sv - randomized scoreboard bench for msk_xor_rd
module tb_msk_xor_rd;
    localparam int DW = 32;
    localparam int MW = 384;
    localparam int NW = MW / DW;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          msk_ld = 1'b0;
    logic [MW-1:0] msk = '0;
    logic          abort = 1'b0;
    logic          busy;
    logic          done;

    msk_xor_rd_if #(.DW(DW)) bus ();

    msk_xor_rd #(.DW(DW), .MW(MW)) dut (
        .clk    (clk),
        .rst    (rst),
        .msk_ld (msk_ld),
        .msk    (msk),
        .abort  (abort),
        .bus    (bus),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            done_cnt = 0;
    int            last_hs_cyc = -10;
    int            ready_mode = 0;
    int            rdy_ph = 0;
    exp_t          sb[$];
    logic [MW-1:0] model_mask = '0;
    int            model_k = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rdy_ph = rdy_ph + 1;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = (rdy_ph % 3 == 0);
            default: bus.out_ready = $urandom_range(0, 1) == 1;
        endcase
    end

    // Accept observer: the reference model turns each accepted word into an expected output.
    always @(negedge clk) begin
        if (!rst && bus.in_valid && bus.in_ready) begin
            exp_t e;
            e.data  = bus.in_data ^ model_mask[MW-1-model_k*DW -: DW];
            e.last  = (model_k == NW - 1);
            e.cyc   = cyc;
            model_k = model_k + 1;
            sb.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_data_hold", bus.out_data, prev_data);
                chk("stall_last_hold", bus.out_last, prev_last);
            end
            if (bus.out_valid && !bus.out_ready) chk("in_ready_when_stalled", bus.in_ready, 0);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", bus.out_data, e.data);
                    chk("out_last", bus.out_last, e.last);
                    if (ready_mode == 0) chk("latency", cyc, e.cyc + 1);
                    if (e.last) last_hs_cyc = cyc;
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_timing", cyc, last_hs_cyc + 1);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end
    end

    task automatic load(input logic [MW-1:0] m);
        msk        = m;
        msk_ld     = 1'b1;
        model_mask = m;
        model_k    = 0;
        @(posedge clk); #1;
        msk_ld = 1'b0;
    endtask

    // Returns early when an abort or reset is injected after the given number of accepted beats.
    task automatic run_stream(input bit fixed, input int reload_at, input int abort_at, input int rst_at);
        int   beats = 0;
        int   guard = 0;
        bit   reloaded = 0;
        logic acc;
        while (beats < NW && guard < 300) begin
            bus.in_valid = 1'b1;
            bus.in_data  = fixed ? 32'hFFFF_FFF0 : $urandom;
            if (beats == reload_at && !reloaded) begin
                msk      = '1;
                msk_ld   = 1'b1;
                reloaded = 1;
            end else begin
                msk_ld = 1'b0;
            end
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk); #1;
            guard++;
            if (acc) beats++;
            if (beats == abort_at) begin
                bus.in_valid = 1'b0;
                msk_ld       = 1'b0;
                abort        = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                sb.delete();
                begin
                    int d0 = done_cnt;
                    @(negedge clk);
                    chk("abort_out_valid", bus.out_valid, 0);
                    chk("abort_busy", busy, 0);
                    repeat (5) @(posedge clk);
                    #1;
                    chk("abort_no_done", done_cnt, d0);
                end
                return;
            end
            if (beats == rst_at) begin
                bus.in_valid = 1'b0;
                #2 rst = 1'b1;
                #1;
                chk("rst_out_data", bus.out_data, 0);
                chk("rst_out_valid", bus.out_valid, 0);
                chk("rst_out_last", bus.out_last, 0);
                chk("rst_done", done, 0);
                chk("rst_busy", busy, 0);
                chk("rst_in_ready", bus.in_ready, 0);
                sb.delete();
                @(posedge clk); #2;
                rst = 1'b0;
                @(posedge clk); #1;
                return;
            end
        end
        bus.in_valid = 1'b0;
        msk_ld       = 1'b0;
        if (guard >= 300) chk("stream_timeout", 1, 0);
    endtask

    task automatic wait_done(input int d0);
        int guard = 0;
        while (done_cnt == d0 && guard < 60) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_count", done_cnt - d0, 1);
        chk("busy_after_done", busy, 0);
        chk("queue_drained", sb.size(), 0);
    endtask

    initial begin
        logic [MW-1:0] m;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_data", bus.out_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_in_ready", bus.in_ready, 0);
        chk("reset_done", done, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < NW; k++) m[MW-1-k*DW -: DW] = DW'(k);

        ready_mode = 0;
        load(m);
        run_stream(1, -1, -1, -1);
        wait_done(done_cnt);

        ready_mode = 1;
        load(m);
        run_stream(1, -1, -1, -1);
        wait_done(done_cnt);

        ready_mode = 0;
        for (int k = 0; k < MW / 32; k++) m[k*32 +: 32] = $urandom;
        load(m);
        run_stream(0, 5, -1, -1);
        wait_done(done_cnt);

        for (int k = 0; k < MW / 32; k++) m[k*32 +: 32] = $urandom;
        load(m);
        run_stream(0, -1, 6, -1);
        load(m);
        run_stream(0, -1, -1, -1);
        wait_done(done_cnt);

        ready_mode = 2;
        for (int k = 0; k < MW / 32; k++) m[k*32 +: 32] = $urandom;
        load(m);
        run_stream(0, -1, -1, -1);
        wait_done(done_cnt);

        ready_mode = 0;
        load(m);
        run_stream(0, -1, -1, 4);

        bus.in_valid = 1'b1;
        bus.in_data  = $urandom;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_in_ready", bus.in_ready, 0);
            chk("idle_out_valid", bus.out_valid, 0);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;

        ready_mode = 2;
        for (int k = 0; k < MW / 32; k++) m[k*32 +: 32] = $urandom;
        load(m);
        run_stream(0, -1, -1, -1);
        wait_done(done_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
